// File: rtl/demux_8x1_wb.sv
// demux_8x1_wb: write-back 1-to-8 slot writer with a one-deep request stage.
// Ports: clk, rst_n, in_valid/in_ready/hold handshake, sel[3:0], din, err_clr,
//        out_we one-hot strobe, q0..q7 held slots, err sticky illegal-sel flag.
// Option: DEMUX_ZERO_SLOT_EN hardwires q0 to zero and drops sel=0 writes.
module demux_8x1_wb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [7:0]       out_we,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic             err
);

`ifdef DEMUX_ZERO_SLOT_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  typedef struct packed {
    logic             v;
    logic [3:0]       sel;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t           st;
  logic             acc;
  logic             ill;
  logic             wr_ok;
  logic [7:0]       we_d;
  logic [WIDTH-1:0] slot [8];

  // Stage always drains in one cycle, so only hold throttles intake.
  assign in_ready = !hold;
  assign acc      = in_valid && in_ready;
  assign ill      = st.v && st.sel[3];

  always_comb begin
    wr_ok = st.v && !st.sel[3];
    if (ZS && st.sel == 4'b0000)
      wr_ok = 1'b0;
    we_d = wr_ok ? (8'b1 << st.sel[2:0]) : 8'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
    end else if (acc) begin
      st.v    <= 1'b1;
      st.sel  <= sel;
      st.data <= din;
    end else begin
      st.v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_we <= '0;
    else
      out_we <= we_d;
  end

  // Set has priority over clear at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (ill)
      err <= 1'b1;
    else if (err_clr)
      err <= 1'b0;
  end

  for (genvar k = 0; k < 8; k++) begin : g_slot
    if (ZS && k == 0) begin : g_zero
      assign slot[k] = '0;
    end else begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          slot[k] <= '0;
        else if (we_d[k])
          slot[k] <= st.data;
      end
    end
  end

  assign q0 = slot[0];
  assign q1 = slot[1];
  assign q2 = slot[2];
  assign q3 = slot[3];
  assign q4 = slot[4];
  assign q5 = slot[5];
  assign q6 = slot[6];
  assign q7 = slot[7];

endmodule

// File: tb/tb_demux_8x1_wb.sv
// tb_demux_8x1_wb: scoreboard bench for demux_8x1_wb.
// Accepted requests are queued and retired one edge later against a slot model.
module tb_demux_8x1_wb;
  localparam int W = 32;

`ifdef DEMUX_ZERO_SLOT_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         hold = 1'b0;
  logic         err_clr = 1'b0;
  logic [3:0]   sel = '0;
  logic [W-1:0] din = '0;
  logic         in_ready;
  logic [7:0]   out_we;
  logic [W-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic         err;
  logic [W-1:0] qa [8];

  always #5 clk = ~clk;

  demux_8x1_wb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .sel(sel), .din(din),
    .err_clr(err_clr), .out_we(out_we),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .err(err)
  );

  assign qa[0] = q0;
  assign qa[1] = q1;
  assign qa[2] = q2;
  assign qa[3] = q3;
  assign qa[4] = q4;
  assign qa[5] = q5;
  assign qa[6] = q6;
  assign qa[7] = q7;

  typedef struct {
    bit         v;
    bit [3:0]   sel;
    bit [W-1:0] d;
  } req_t;

  req_t         sbq [$];
  logic [W-1:0] mdl [8];
  bit           err_m;
  int           checks = 0;
  int           fails = 0;

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(logic [7:0] we_e);
    chk("out_we", {24'h0, out_we}, {24'h0, we_e});
    chk("err", {31'h0, err}, {31'h0, err_m});
    for (int k = 0; k < 8; k++)
      chk($sformatf("q%0d", k), qa[k], mdl[k]);
  endtask

  task automatic model_reset();
    sbq.delete();
    for (int k = 0; k < 8; k++)
      mdl[k] = '0;
    err_m = 1'b0;
  endtask

  // Called at posedge+1: drive, check in_ready, cross edge, retire.
  task automatic step(bit v, bit h, bit [3:0] s, bit [W-1:0] d, bit c);
    req_t       it;
    logic [7:0] we_e;
    in_valid = v;
    hold     = h;
    sel      = s;
    din      = d;
    err_clr  = c;
    #1;
    chk("in_ready", {31'h0, in_ready}, {31'h0, !h});
    @(posedge clk);
    #1;
    we_e = '0;
    it   = '{v: 1'b0, sel: 4'h0, d: '0};
    if (sbq.size() > 0)
      it = sbq.pop_front();
    if (it.v && it.sel[3]) begin
      err_m = 1'b1;
    end else begin
      if (it.v && !(ZS && it.sel == 4'h0)) begin
        we_e = 8'b1 << it.sel[2:0];
        mdl[it.sel[2:0]] = it.d;
      end
      if (c)
        err_m = 1'b0;
    end
    chk_all(we_e);
    if (v && !h)
      sbq.push_back('{v: 1'b1, sel: s, d: d});
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 4'h0, '0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all(8'h00);
    rst_n = 1'b1;

    step(1'b1, 1'b0, 4'd3, 32'hDEADBEEF, 1'b0);
    idle(3);

    for (int k = 0; k < 8; k++)
      step(1'b1, 1'b0, 4'(k), W'(k) * 32'h1111, 1'b0);
    idle(2);

    step(1'b1, 1'b0, 4'b1010, 32'h0BAD0001, 1'b0);
    step(1'b1, 1'b0, 4'b1011, 32'h0BAD0002, 1'b1);
    step(1'b0, 1'b0, 4'h0, '0, 1'b1);
    step(1'b0, 1'b0, 4'h0, '0, 1'b1);
    idle(1);

    step(1'b1, 1'b0, 4'd2, 32'hA5A5A5A5, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 4'd6, 32'h66666666, 1'b0);
    idle(2);

    step(1'b1, 1'b0, 4'd0, 32'h00001234, 1'b0);
    idle(2);

    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) == 0),
           4'($urandom_range(0, 15)),
           W'($urandom),
           1'($urandom_range(0, 3) == 0));
    idle(2);

    step(1'b1, 1'b0, 4'd5, 32'h55550005, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all(8'h00);
    @(posedge clk);
    #1;
    chk_all(8'h00);
    rst_n = 1'b1;
    idle(3);

    step(1'b1, 1'b0, 4'd7, 32'h77777777, 1'b0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
